// File: rtl/fsm_dispatch.sv
// fsm_dispatch -- top-level sequencer of the multicycle control unit.
//
// Fetches an instruction over a req/ack handshake, latches it into the IR,
// decodes the one-hot opcode class against four unit masks, launches exactly
// one execution sub-FSM with a single-cycle start pulse and waits for its done.
// Illegal classes, done from the wrong unit and hung units all end in TRAP.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   run         permits leaving IDLE and continuing after a completed instruction
//   imem_req    instruction fetch request (FETCH state)
//   imem_ack    instruction word valid this cycle
//   load_ir     IR write enable, imem_req & imem_ack
//   code        one-hot opcode class, valid in the cycle after load_ir
//   start[3:0]  one-hot start pulse to sub-FSMs 0..3
//   done[3:0]   done flags from sub-FSMs 0..3
//   busy        high outside IDLE and TRAP
//   trap        high in TRAP
//   trap_cause  01 illegal, 10 spurious done, 11 timeout, 00 otherwise
//   trap_clr    leave TRAP
//   retired     completed-instruction count (wraps)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | parked, waits for run
// FETCH    | imem_req high until imem_ack; load_ir on the ack cycle
// DECODE   | match code against unit masks, pick sel or trap illegal
// DISPATCH | start[sel] for one cycle, clear timeout counter
// WAIT     | wait for done[sel]; wrong done or timeout traps
// TRAP     | hold trap/trap_cause until trap_clr

module fsm_dispatch #(
   parameter logic [31:0] UNIT_MASK0 = 32'h0000_7070,
   parameter logic [31:0] UNIT_MASK1 = 32'h0000_0003,
   parameter logic [31:0] UNIT_MASK2 = 32'h0000_0080,
   parameter logic [31:0] UNIT_MASK3 = 32'h0000_0300,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   output logic        imem_req,
   input  logic        imem_ack,
   output logic        load_ir,
   input  logic [31:0] code,
   output logic [3:0]  start,
   input  logic [3:0]  done,
   output logic        busy,
   output logic        trap,
   output logic [1:0]  trap_cause,
   input  logic        trap_clr,
   output logic [15:0] retired
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_FETCH    = 3'd1;
   localparam logic [2:0] S_DECODE   = 3'd2;
   localparam logic [2:0] S_DISPATCH = 3'd3;
   localparam logic [2:0] S_WAIT     = 3'd4;
   localparam logic [2:0] S_TRAP     = 3'd5;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
   localparam logic [1:0] CAUSE_SPURIOUS = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   logic [2:0]  state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  cause_q, cause_d;
   logic [15:0] retired_q, retired_d;

   logic [3:0]  match;
   logic [1:0]  match_idx;
   logic        match_one;
   logic [7:0]  cnt_inc;

   assign match[0] = |(code & UNIT_MASK0);
   assign match[1] = |(code & UNIT_MASK1);
   assign match[2] = |(code & UNIT_MASK2);
   assign match[3] = |(code & UNIT_MASK3);

   // Only a single matching unit is legal; zero or several matches trap.
   always_comb begin
      match_idx = 2'd0;
      match_one = 1'b0;
      case (match)
         4'b0001: begin match_one = 1'b1; match_idx = 2'd0; end
         4'b0010: begin match_one = 1'b1; match_idx = 2'd1; end
         4'b0100: begin match_one = 1'b1; match_idx = 2'd2; end
         4'b1000: begin match_one = 1'b1; match_idx = 2'd3; end
         default: ;
      endcase
   end

   assign cnt_inc = cnt_q + 8'd1;

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      cause_d   = cause_q;
      retired_d = retired_q;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ack) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (match_one) begin
               sel_d   = match_idx;
               state_d = S_DISPATCH;
            end else begin
               cause_d = CAUSE_ILLEGAL;
               state_d = S_TRAP;
            end
         end
         S_DISPATCH: begin
            cnt_d   = 8'd0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // done from the selected unit wins over any other bit in the same cycle
            if (done[sel_q]) begin
               retired_d = retired_q + 16'd1;
               state_d   = run ? S_FETCH : S_IDLE;
            end else if (|done) begin
               cause_d = CAUSE_SPURIOUS;
               state_d = S_TRAP;
            end else begin
               cnt_d = cnt_inc;
               // trap on the TIMEOUT-th silent WAIT cycle
               if (cnt_inc >= TIMEOUT_C) begin
                  cause_d = CAUSE_TIMEOUT;
                  state_d = S_TRAP;
               end
            end
         end
         S_TRAP: begin
            if (trap_clr) begin
               cause_d = CAUSE_NONE;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sel_q     <= 2'd0;
         cnt_q     <= 8'd0;
         cause_q   <= CAUSE_NONE;
         retired_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         cause_q   <= cause_d;
         retired_q <= retired_d;
      end
   end

   assign imem_req   = (state_q == S_FETCH);
   assign load_ir    = imem_req & imem_ack;
   assign start      = (state_q == S_DISPATCH) ? (4'b0001 << sel_q) : 4'b0000;
   assign busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                       (state_q == S_DISPATCH) || (state_q == S_WAIT);
   assign trap       = (state_q == S_TRAP);
   assign trap_cause = cause_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_fsm_dispatch.sv
module tb_fsm_dispatch;

   localparam int TO = 15;
   localparam logic [31:0] M0 = 32'h0000_7070;
   localparam logic [31:0] M1 = 32'h0000_0003;
   localparam logic [31:0] M2 = 32'h0000_0080;
   localparam logic [31:0] M3 = 32'h0000_0300;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic        imem_req;
   logic        imem_ack;
   logic        load_ir;
   logic [31:0] code;
   logic [3:0]  start;
   logic [3:0]  done;
   logic        busy;
   logic        trap;
   logic [1:0]  trap_cause;
   logic        trap_clr;
   logic [15:0] retired;

   int checks   = 0;
   int failures = 0;

   logic [15:0] exp_retired;
   logic [1:0]  last_cause;
   logic        last_run;
   logic [31:0] masks [4];

   typedef struct {
      logic [31:0] code;
      int          ack_lat;
      int          done_lat;   // WAIT cycle carrying dv; 0 = never
      logic [3:0]  dv;
      logic        run_after;
      logic [3:0]  es;         // expected start vector
      logic [1:0]  ec;         // expected outcome: 00 retire, else trap cause
   } vec_t;

   vec_t vecs [12];

   fsm_dispatch #(
      .UNIT_MASK0(M0), .UNIT_MASK1(M1), .UNIT_MASK2(M2), .UNIT_MASK3(M3),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .imem_req(imem_req), .imem_ack(imem_ack), .load_ir(load_ir),
      .code(code), .start(start), .done(done),
      .busy(busy), .trap(trap), .trap_cause(trap_cause),
      .trap_clr(trap_clr), .retired(retired)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: which unit owns the code, and how the WAIT phase must end.
   function automatic void model(input logic [31:0] c, input int dl, input logic [3:0] dv,
                                 output logic [3:0] es, output logic [1:0] ec);
      int hits = 0;
      int unit = 0;
      for (int i = 0; i < 4; i++) begin
         if ((c & masks[i]) != 0) begin
            hits++;
            unit = i;
         end
      end
      es = 4'b0000;
      if (hits != 1) begin
         ec = 2'b01;
         return;
      end
      es = 4'b0001 << unit;
      if (dl == 0 || dl > TO)   ec = 2'b11;
      else if (dv[unit])        ec = 2'b00;
      else if (dv != 4'b0000)   ec = 2'b10;
      else                      ec = 2'b11;
   endfunction

   // Entered at a falling edge with the DUT in FETCH.
   task automatic do_instr(input logic [31:0] c, input int ack_lat, input int done_lat,
                           input logic [3:0] dv, input logic run_after,
                           input logic [3:0] es, input logic [1:0] ec);
      int end_w;
      for (int k = 0; k <= ack_lat; k++) begin
         chk("fetch_req", imem_req, 1);
         chk("fetch_busy", busy, 1);
         imem_ack = (k == ack_lat);
         code     = $urandom;
         done     = 4'($urandom);
         #1;
         chk("fetch_load_ir", load_ir, (k == ack_lat));
         @(negedge clk);
      end
      code     = c;
      imem_ack = 1'($urandom);
      done     = 4'($urandom);
      #1;
      chk("decode_req", imem_req, 0);
      chk("decode_load_ir", load_ir, 0);
      chk("decode_start", start, 0);
      chk("decode_busy", busy, 1);
      @(negedge clk);
      code = $urandom;
      if (ec == 2'b01) begin
         chk("illegal_trap", trap, 1);
         chk("illegal_cause", trap_cause, ec);
         chk("illegal_start", start, 0);
         chk("illegal_busy", busy, 0);
         chk("illegal_retired", retired, exp_retired);
         imem_ack   = 1'b0;
         done       = 4'b0000;
         last_cause = ec;
         last_run   = run_after;
         return;
      end
      chk("dispatch_start", start, es);
      chk("dispatch_busy", busy, 1);
      done = 4'($urandom);
      @(negedge clk);
      run   = run_after;
      end_w = (ec == 2'b11) ? TO : done_lat;
      for (int w = 1; w <= end_w; w++) begin
         chk("wait_start", start, 0);
         chk("wait_trap", trap, 0);
         chk("wait_busy", busy, 1);
         chk("wait_req", imem_req, 0);
         done = (w == done_lat) ? dv : 4'b0000;
         @(negedge clk);
      end
      done     = 4'b0000;
      imem_ack = 1'b0;
      if (ec == 2'b00) begin
         exp_retired++;
         chk("retire_trap", trap, 0);
         chk("retire_next_req", imem_req, run_after);
         chk("retire_busy", busy, run_after);
      end else begin
         chk("trap_rise", trap, 1);
         chk("trap_cause", trap_cause, ec);
         chk("trap_busy", busy, 0);
      end
      chk("retired", retired, exp_retired);
      last_cause = ec;
      last_run   = run_after;
   endtask

   task automatic clear_trap();
      @(negedge clk);
      chk("trap_hold", trap, 1);
      chk("trap_hold_cause", trap_cause, last_cause);
      trap_clr = 1'b1;
      @(negedge clk);
      trap_clr = 1'b0;
      chk("clr_trap", trap, 0);
      chk("clr_cause", trap_cause, 0);
      chk("clr_busy", busy, 0);
      chk("clr_req", imem_req, 0);
   endtask

   task automatic resume();
      if (last_cause != 2'b00) clear_trap();
      if (last_cause != 2'b00 || !last_run) begin
         run = 1'b1;
         @(negedge clk);
         chk("leave_idle", imem_req, 1);
      end
   endtask

   logic [31:0] rc;
   logic [3:0]  rdv, res;
   logic [1:0]  rec;
   logic        rrun;
   int          u, r, m, ral, rdl;

   initial begin
      rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; code = '0; done = '0; trap_clr = 1'b0;
      exp_retired = '0; last_cause = '0; last_run = 1'b1;
      masks[0] = M0; masks[1] = M1; masks[2] = M2; masks[3] = M3;

      vecs[0]  = '{32'h0000_1000, 0, 4,  4'b0001, 1'b1, 4'b0001, 2'b00};  // ALU, 7-cycle instr
      vecs[1]  = '{32'h0000_0002, 3, 1,  4'b0010, 1'b1, 4'b0010, 2'b00};  // fetch wait states
      vecs[2]  = '{32'h0000_0000, 0, 0,  4'b0000, 1'b1, 4'b0000, 2'b01};  // no unit
      vecs[3]  = '{32'h0000_1001, 0, 0,  4'b0000, 1'b1, 4'b0000, 2'b01};  // two units
      vecs[4]  = '{32'h0000_0080, 0, 2,  4'b0001, 1'b1, 4'b0100, 2'b10};  // spurious done
      vecs[5]  = '{32'h0000_0080, 1, 2,  4'b0101, 1'b1, 4'b0100, 2'b00};  // own done wins
      vecs[6]  = '{32'h0000_0200, 0, 0,  4'b0000, 1'b1, 4'b1000, 2'b11};  // timeout
      vecs[7]  = '{32'h0000_0100, 0, TO, 4'b1000, 1'b1, 4'b1000, 2'b00};  // done on last WAIT
      vecs[8]  = '{32'h0000_0010, 2, 1,  4'b1111, 1'b1, 4'b0001, 2'b00};
      vecs[9]  = '{32'h0000_0001, 1, 3,  4'b1100, 1'b1, 4'b0010, 2'b10};
      vecs[10] = '{32'h0000_4000, 0, 2,  4'b0001, 1'b0, 4'b0001, 2'b00};  // run dropped mid-instr
      vecs[11] = '{32'h0000_0800, 0, 0,  4'b0000, 1'b1, 4'b0000, 2'b01};  // bit outside all masks

      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_start", start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_trap", trap, 0);
      chk("rst_cause", trap_cause, 0);
      chk("rst_retired", retired, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_hold_req", imem_req, 0);
      chk("idle_hold_busy", busy, 0);
      run = 1'b1;
      @(negedge clk);
      chk("leave_idle", imem_req, 1);

      for (int i = 0; i < 12; i++) begin
         do_instr(vecs[i].code, vecs[i].ack_lat, vecs[i].done_lat, vecs[i].dv,
                  vecs[i].run_after, vecs[i].es, vecs[i].ec);
         resume();
      end

      for (int n = 0; n < 150; n++) begin
         u = $urandom_range(0, 3);
         r = $urandom_range(0, 9);
         if (r < 7) begin
            rc = masks[u] & $urandom;
            if (rc == 0) rc = masks[u];
            if (r < 3) rc = rc | ($urandom & ~(M0 | M1 | M2 | M3));
         end else if (r == 7) begin
            rc = 32'd1 << $urandom_range(0, 31);
         end else begin
            rc = masks[u] | masks[(u + 1) % 4];
         end
         rdl = $urandom_range(1, TO + 1);
         m   = $urandom_range(0, 9);
         if (m < 6)      rdv = 4'($urandom) | (4'b0001 << u);
         else if (m < 8) rdv = 4'($urandom) & ~(4'b0001 << u);
         else begin
            rdv = 4'b0001 << u;
            rdl = 0;
         end
         ral  = $urandom_range(0, 3);
         rrun = ($urandom_range(0, 3) != 0);
         model(rc, rdl, rdv, res, rec);
         do_instr(rc, ral, rdl, rdv, rrun, res, rec);
         resume();
      end

      // asynchronous reset in the middle of WAIT (DUT is in FETCH here)
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      code     = 32'h0000_0200;
      @(negedge clk);
      chk("rstwait_start", start, 4'b1000);
      done = 4'b0000;
      repeat (2) @(negedge clk);
      chk("rstwait_busy_pre", busy, 1);
      #2;
      imem_ack = 1'b1;
      rst_n    = 1'b0;
      #1;
      chk("rstwait_req", imem_req, 0);
      chk("rstwait_load_ir", load_ir, 0);
      chk("rstwait_start0", start, 0);
      chk("rstwait_busy", busy, 0);
      chk("rstwait_trap", trap, 0);
      chk("rstwait_cause", trap_cause, 0);
      chk("rstwait_retired", retired, 0);
      run      = 1'b0;
      imem_ack = 1'b0;
      exp_retired = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", busy, 0);

      // retirement counter wrap
      force dut.retired_q = 16'hFFFF;
      @(negedge clk);
      release dut.retired_q;
      exp_retired = 16'hFFFF;
      run = 1'b1;
      @(negedge clk);
      chk("wrap_leave_idle", imem_req, 1);
      do_instr(32'h0000_2000, 0, 4, 4'b0001, 1'b1, 4'b0001, 2'b00);
      chk("wrap_zero", retired, 16'h0000);
      do_instr(32'h0000_0300, 0, 2, 4'b1000, 1'b0, 4'b1000, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fsm_dispatch.md
# fsm_dispatch

Top-level sequencer of the multicycle control unit. It fetches each instruction over a request/acknowledge handshake and latches it into the instruction register. It then dispatches exactly one execution sub-FSM (ALU, load/store, branch, jump) with a one-cycle `start` pulse and waits for that unit's one-cycle `done`. It is the initiator side of the start/done handshake that every `fsm_*` unit responds to, and it traps on illegal, spurious or hung instructions.

## Interface
- `UNIT_MASK0`, default 32'h0000_7070: `code` bits owned by unit 0 (ALU).
- `UNIT_MASK1`, default 32'h0000_0003: `code` bits owned by unit 1 (load/store).
- `UNIT_MASK2`, default 32'h0000_0080: `code` bits owned by unit 2 (branch).
- `UNIT_MASK3`, default 32'h0000_0300: `code` bits owned by unit 3 (jump).
- `TIMEOUT`, default 15: maximum WAIT cycles without `done` (1..255).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  allows leaving IDLE.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  instruction word valid this cycle.
- `load_ir`  out  1  IR write enable; equals `imem_req & imem_ack`.
- `code`  in  32  one-hot opcode class from the opdecoder. It is valid in the cycle after `load_ir`.
- `start`  out  4  one-hot start pulse to sub-FSMs 0..3.
- `done`  in  4  done flags from sub-FSMs 0..3.
- `busy`  out  1  high in every state except IDLE and TRAP.
- `trap`  out  1  high in TRAP.
- `trap_cause`  out  2  01 illegal, 10 spurious done, 11 timeout; 00 otherwise.
- `trap_clr`  in  1  leave TRAP.
- `retired`  out  16  count of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, DISPATCH, WAIT, TRAP.
- On reset, all outputs are 0, `retired` is 0, the state is IDLE, `sel` is 0 and the timeout counter is 0.
- **IDLE**: go to FETCH when `run`=1.
- **FETCH**: drive `imem_req`=1 and hold it until `imem_ack`. In the `imem_ack` cycle, `load_ir`=1 and the next state is DECODE.
- **DECODE**: compute `m[i] = |(code & UNIT_MASKi)`.
  - Exactly one `m[i]` set: register `sel`=i and go to DISPATCH.
  - Zero or more than one set: go to TRAP with cause 01.
- **DISPATCH**: `start[sel]`=1 for this cycle only. Clear the timeout counter. Go to WAIT.
- **WAIT**:
  - `done[sel]`=1: increment `retired` (wraps FFFF→0000). Go to FETCH if `run`=1, else IDLE.
  - Otherwise, any other `done` bit set: go to TRAP with cause 10. `done[sel]` has priority if it arrives together with another bit.
  - Otherwise the counter increments. On the cycle it would exceed `TIMEOUT`, go to TRAP with cause 11.
- **TRAP**: hold `trap`=1 and `trap_cause`. `trap_clr`=1 clears the cause and goes to IDLE. `retired` is not incremented.
- `run` deasserted mid-instruction does not abort it. It is checked only in IDLE and at WAIT completion.
- `rst_n` low in any state forces the reset values immediately, without waiting for a clock edge. Any in-flight sub-FSM handshake is abandoned.
- `done` outside WAIT is ignored.

## Timing
- All state outputs (`imem_req`, `start`, `busy`, `trap`, `trap_cause`) are decoded from the registered state. `load_ir` is the only output combinational on an input (`imem_ack`).
- Minimum instruction latency with zero-wait fetch is FETCH 1 + DECODE 1 + DISPATCH 1 + WAIT n cycles.
- With the ALU sub-FSM (DECODE, EXECUTE, WRITEBACK, DONE), `done` rises 4 cycles after the `start` cycle. This gives 7 cycles per ALU instruction and the next `imem_req` in cycle 8.
- `start` is never asserted on two consecutive cycles. At most one `start` bit is ever high.
- The timeout fires after exactly `TIMEOUT` WAIT cycles without `done`, so with default 15 `trap` rises 16 cycles after DISPATCH.

## Test plan
- **Reset and idle:** reset, then `run`=1, `imem_ack` tied 1, `code`=32'h0000_1000 (ALU), ALU model with `done` 4 cycles after `start` → `start`=4'b0001 in cycle 3 after leaving IDLE, `retired`=1 after cycle 7, `imem_req` high again in cycle 8.
- **Fetch wait states:** `imem_ack` delayed 3 cycles → `imem_req` held high 4 cycles, `load_ir` a single pulse on the ack cycle.
- **Illegal code:** `code`=0, then `code`=32'h0000_1001 (two units matched) → TRAP with cause 01, no `start` pulse. `trap_clr` → IDLE.
- **Spurious done:** unit 2 dispatched, `done`=4'b0001 in WAIT → cause 10. `done`=4'b0101 instead → completes normally, `retired` increments.
- **Timeout:** unit 3 never responds → `trap` rises exactly 16 cycles after DISPATCH, cause 11, `retired` unchanged.
- **Reset and wrap:** `rst_n` pulsed low mid-WAIT → all outputs 0 and IDLE without waiting for a clock edge. Separately, preload 0xFFFF retirements (force) plus one more → `retired`=0.
